// File: rtl/sram_mbist_pkg.sv
// Shared types for the March C- BIST: controller states, op kinds and the element table.
// The table encodes each element's sweep direction, ops per address and data polarity.
package sram_mbist_pkg;

   localparam int NUM_ELEM = 6;
   localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_e;

   // pol0/pol1: 0 selects the background, 1 selects its inverse.
   typedef struct packed {
      logic desc;
      logic two_ops;
      op_e  op0;
      op_e  op1;
      logic pol0;
      logic pol1;
   } elem_t;

   function automatic elem_t elem_info(input logic [2:0] idx);
      elem_t e;
      case (idx)
         3'd0:    e = '{desc: 1'b0, two_ops: 1'b0, op0: OP_WR, op1: OP_WR, pol0: 1'b0, pol1: 1'b0};
         3'd1:    e = '{desc: 1'b0, two_ops: 1'b1, op0: OP_RD, op1: OP_WR, pol0: 1'b0, pol1: 1'b1};
         3'd2:    e = '{desc: 1'b0, two_ops: 1'b1, op0: OP_RD, op1: OP_WR, pol0: 1'b1, pol1: 1'b0};
         3'd3:    e = '{desc: 1'b1, two_ops: 1'b1, op0: OP_RD, op1: OP_WR, pol0: 1'b0, pol1: 1'b1};
         3'd4:    e = '{desc: 1'b1, two_ops: 1'b1, op0: OP_RD, op1: OP_WR, pol0: 1'b1, pol1: 1'b0};
         3'd5:    e = '{desc: 1'b0, two_ops: 1'b0, op0: OP_RD, op1: OP_RD, pol0: 1'b0, pol1: 1'b0};
         default: e = '{desc: 1'b0, two_ops: 1'b0, op0: OP_WR, op1: OP_WR, pol0: 1'b0, pol1: 1'b0};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sram_mbist_addr_gen.sv
// March sequencer: element index, per-address op index and up/down address counter.
// Advances one op per adv_i; load_i restarts at element 0, address 0.
module sram_mbist_addr_gen
   import sram_mbist_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              adv_i,
   output op_e               op_o,
   output logic              pol_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [2:0]        elem_o,
   output logic              test_last_o
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              opi_q, opi_d;
   elem_t             cur, nxt;
   logic              last_op, last_addr;

   always_comb begin
      cur       = elem_info(elem_q);
      nxt       = elem_info(elem_q + 3'd1);
      last_op   = ~cur.two_ops | opi_q;
      last_addr = cur.desc ? (addr_q == '0) : (addr_q == ADDR_MAX);
      elem_d    = elem_q;
      addr_d    = addr_q;
      opi_d     = opi_q;
      if (load_i) begin
         elem_d = '0;
         addr_d = '0;
         opi_d  = 1'b0;
      end else if (adv_i) begin
         if (!last_op) begin
            opi_d = 1'b1;
         end else begin
            opi_d = 1'b0;
            if (last_addr) begin
               // next element starts at the end matching its own direction
               elem_d = elem_q + 3'd1;
               addr_d = nxt.desc ? ADDR_MAX : '0;
            end else begin
               addr_d = cur.desc ? (addr_q - 1'b1) : (addr_q + 1'b1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         elem_q <= '0;
         addr_q <= '0;
         opi_q  <= 1'b0;
      end else begin
         elem_q <= elem_d;
         addr_q <= addr_d;
         opi_q  <= opi_d;
      end
   end

   assign op_o        = opi_q ? cur.op1 : cur.op0;
   assign pol_o       = opi_q ? cur.pol1 : cur.pol0;
   assign addr_o      = addr_q;
   assign elem_o      = elem_q;
   assign test_last_o = last_op & last_addr & (elem_q == LAST_ELEM);

endmodule

// File: rtl/sram_mbist_1rf.sv
// March C- BIST controller for a single-port RF macro; functional pins pass through when idle.
// One macro op per cycle while running, read compare one cycle after issue; start ignored while busy.
module sram_mbist_1rf
   import sram_mbist_pkg::*;
#(
   parameter int              ADDR_W = 6,
   parameter int              DATA_W = 32,
   parameter logic [DATA_W-1:0] BG   = '0
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [ADDR_W-1:0] bist_fail_addr,
   output logic [2:0]        bist_fail_elem,
   output logic [7:0]        bist_err_cnt,
   input  logic              func_cen,
   input  logic              func_gwen,
   input  logic [DATA_W-1:0] func_wen,
   input  logic [ADDR_W-1:0] func_a,
   input  logic [DATA_W-1:0] func_d,
   output logic [DATA_W-1:0] func_q,
   output logic              mem_cen,
   output logic              mem_gwen,
   output logic [DATA_W-1:0] mem_wen,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   input  logic [DATA_W-1:0] mem_q
);

   state_e            state_q, state_d;
   logic              start_run;
   logic              running;

   op_e               gen_op;
   logic              gen_pol;
   logic [ADDR_W-1:0] gen_addr;
   logic [2:0]        gen_elem;
   logic              gen_test_last;
   logic [DATA_W-1:0] gen_data;

   logic              rd_vld_q, rd_vld_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
   logic [2:0]        cmp_elem_q, cmp_elem_d;
   logic              miscmp;

   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]        fail_elem_q, fail_elem_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   assign running  = (state_q == ST_RUN);
   assign gen_data = gen_pol ? ~BG : BG;

   sram_mbist_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk_i       (CLK),
      .rst_ni      (RESETN),
      .load_i      (start_run),
      .adv_i       (running),
      .op_o        (gen_op),
      .pol_o       (gen_pol),
      .addr_o      (gen_addr),
      .elem_o      (gen_elem),
      .test_last_o (gen_test_last)
   );

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bist_start) begin
               state_d   = ST_RUN;
               start_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (gen_test_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Compare stage: the macro returns Q one cycle after the read is issued.
   always_comb begin
      rd_vld_d   = running && (gen_op == OP_RD);
      exp_d      = gen_data;
      cmp_addr_d = gen_addr;
      cmp_elem_d = gen_elem;
      miscmp     = rd_vld_q && (mem_q != exp_q);
   end

   always_comb begin
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      err_cnt_d   = err_cnt_q;
      if (start_run) begin
         done_d      = 1'b0;
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_elem_d = '0;
         err_cnt_d   = '0;
      end else begin
         if (state_q == ST_DRAIN) done_d = 1'b1;
         if (miscmp) begin
            fail_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!fail_q) begin
               fail_addr_d = cmp_addr_q;
               fail_elem_d = cmp_elem_q;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         rd_vld_q    <= 1'b0;
         exp_q       <= '0;
         cmp_addr_q  <= '0;
         cmp_elem_q  <= '0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rd_vld_q    <= rd_vld_d;
         exp_q       <= exp_d;
         cmp_addr_q  <= cmp_addr_d;
         cmp_elem_q  <= cmp_elem_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Pin mux is purely combinational on state so reset hands the macro back at once.
   always_comb begin
      mem_cen  = func_cen;
      mem_gwen = func_gwen;
      mem_wen  = func_wen;
      mem_a    = func_a;
      mem_d    = func_d;
      case (state_q)
         ST_RUN: begin
            mem_cen  = 1'b0;
            mem_gwen = (gen_op == OP_RD);
            mem_wen  = (gen_op == OP_RD) ? '1 : '0;
            mem_a    = gen_addr;
            mem_d    = gen_data;
         end
         ST_DRAIN: begin
            mem_cen  = 1'b1;
            mem_gwen = 1'b1;
            mem_wen  = '1;
            mem_a    = gen_addr;
            mem_d    = BG;
         end
         default: ;
      endcase
   end

   assign func_q         = mem_q;
   assign bist_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bist_done      = done_q;
   assign bist_fail      = fail_q;
   assign bist_fail_addr = fail_addr_q;
   assign bist_fail_elem = fail_elem_q;
   assign bist_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sram_mbist_1rf.sv
// Bench for sram_mbist_1rf: behavioural macro model with optional faults and a March C- reference.
module tb_sram_mbist_1rf;

   localparam int          AW    = 6;
   localparam int          DW    = 32;
   localparam int          DEPTH = 64;
   localparam int          NOPS  = 640;
   localparam logic [DW-1:0] BG  = 32'h0000_0000;

   logic          CLK = 1'b0;
   logic          RESETN;
   logic          bist_start;
   logic          bist_busy, bist_done, bist_fail;
   logic [AW-1:0] bist_fail_addr;
   logic [2:0]    bist_fail_elem;
   logic [7:0]    bist_err_cnt;
   logic          func_cen, func_gwen;
   logic [DW-1:0] func_wen, func_d, func_q;
   logic [AW-1:0] func_a;
   logic          mem_cen, mem_gwen;
   logic [DW-1:0] mem_wen, mem_d, mem_q;
   logic [AW-1:0] mem_a;

   sram_mbist_1rf #(.ADDR_W(AW), .DATA_W(DW), .BG(BG)) dut (
      .CLK            (CLK),
      .RESETN         (RESETN),
      .bist_start     (bist_start),
      .bist_busy      (bist_busy),
      .bist_done      (bist_done),
      .bist_fail      (bist_fail),
      .bist_fail_addr (bist_fail_addr),
      .bist_fail_elem (bist_fail_elem),
      .bist_err_cnt   (bist_err_cnt),
      .func_cen       (func_cen),
      .func_gwen      (func_gwen),
      .func_wen       (func_wen),
      .func_a         (func_a),
      .func_d         (func_d),
      .func_q         (func_q),
      .mem_cen        (mem_cen),
      .mem_gwen       (mem_gwen),
      .mem_wen        (mem_wen),
      .mem_a          (mem_a),
      .mem_d          (mem_d),
      .mem_q          (mem_q)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Macro model; fault 1 = addr 5 bit 3 stuck at 1, fault 2 = writes to addr 10 lost.
   logic [DW-1:0] mem_arr  [DEPTH];
   logic [DW-1:0] init_img [DEPTH];
   logic [DW-1:0] q_r = '0;
   int            fault_kind = 0;
   logic          preload = 1'b0;

   always @(posedge CLK) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_img[i];
      end else if (!mem_cen) begin
         if (!mem_gwen) begin
            if (!(fault_kind == 2 && mem_a == 6'd10))
               mem_arr[mem_a] <= (mem_arr[mem_a] & mem_wen) | (mem_d & ~mem_wen);
         end else begin
            q_r <= mem_arr[mem_a] | ((fault_kind == 1 && mem_a == 6'd5) ? 32'h8 : 32'h0);
         end
      end
   end
   assign mem_q = q_r;

   // March C- as a list of elements: direction, op count, whether op0 reads, data polarities.
   int el_desc [6] = '{0, 0, 0, 1, 1, 0};
   int el_nop  [6] = '{1, 2, 2, 2, 2, 1};
   int el_rd0  [6] = '{0, 1, 1, 1, 1, 1};
   int el_p0   [6] = '{0, 0, 1, 0, 1, 0};
   int el_p1   [6] = '{0, 1, 0, 1, 0, 0};

   logic          exp_w [NOPS];
   logic [AW-1:0] exp_a [NOPS];
   logic [DW-1:0] exp_d [NOPS];
   int            ref_err, ref_faddr, ref_felem;

   task automatic build_ref(input int fk);
      logic [DW-1:0] m [DEPTH];
      logic [DW-1:0] pat, rd;
      int            n, a, is_rd;
      logic [31:0]   a32;
      for (int i = 0; i < DEPTH; i++) m[i] = init_img[i];
      n = 0; ref_err = 0; ref_faddr = 0; ref_felem = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < DEPTH; k++) begin
            a = (el_desc[e] != 0) ? (DEPTH - 1 - k) : k;
            a32 = a;
            for (int j = 0; j < el_nop[e]; j++) begin
               is_rd = (j == 0) ? el_rd0[e] : 0;
               pat   = (((j == 0) ? el_p0[e] : el_p1[e]) != 0) ? ~BG : BG;
               exp_w[n] = (is_rd == 0);
               exp_a[n] = a32[AW-1:0];
               exp_d[n] = pat;
               n++;
               if (is_rd != 0) begin
                  rd = m[a] | ((fk == 1 && a == 5) ? 32'h8 : 32'h0);
                  if (rd !== pat) begin
                     if (ref_err == 0) begin
                        ref_faddr = a;
                        ref_felem = e;
                     end
                     if (ref_err < 255) ref_err++;
                  end
               end else if (!(fk == 2 && a == 10)) begin
                  m[a] = pat;
               end
            end
         end
      end
   endtask

   int busy_cnt = 0, op_cnt = 0, op_bad = 0, cen_hi_cnt = 0;
   bit mon_en = 1'b0;

   always @(negedge CLK) begin
      if (mon_en && bist_busy) begin
         busy_cnt++;
         if (mem_cen) begin
            cen_hi_cnt++;
         end else begin
            if (op_cnt < NOPS) begin
               if (mem_gwen !== !exp_w[op_cnt] || mem_a !== exp_a[op_cnt] ||
                   mem_wen !== (exp_w[op_cnt] ? 32'h0 : 32'hFFFF_FFFF) ||
                   (exp_w[op_cnt] && mem_d !== exp_d[op_cnt]))
                  op_bad++;
            end else begin
               op_bad++;
            end
            op_cnt++;
         end
      end
   end

   task automatic rand_func();
      func_cen  = 1'($urandom);
      func_gwen = 1'($urandom);
      func_wen  = $urandom;
      func_a    = AW'($urandom);
      func_d    = $urandom;
   endtask

   task automatic chk_passthru(input string tag);
      chk({tag, "_cen"},  32'(mem_cen),  32'(func_cen));
      chk({tag, "_gwen"}, 32'(mem_gwen), 32'(func_gwen));
      chk({tag, "_wen"},  mem_wen,       func_wen);
      chk({tag, "_a"},    32'(mem_a),    32'(func_a));
      chk({tag, "_d"},    mem_d,         func_d);
   endtask

   task automatic chk_bist_zero(input string tag);
      chk({tag, "_busy"}, 32'(bist_busy),      0);
      chk({tag, "_done"}, 32'(bist_done),      0);
      chk({tag, "_fail"}, 32'(bist_fail),      0);
      chk({tag, "_faddr"},32'(bist_fail_addr), 0);
      chk({tag, "_felem"},32'(bist_fail_elem), 0);
      chk({tag, "_err"},  32'(bist_err_cnt),   0);
   endtask

   task automatic run_bist(input int fk, input int glitch, input string nm);
      int cyc;
      for (int i = 0; i < DEPTH; i++) init_img[i] = $urandom;
      if (fk == 2) init_img[10] = $urandom | 32'h1;
      fault_kind = fk;
      @(negedge CLK) preload = 1'b1;
      @(negedge CLK) preload = 1'b0;
      build_ref(fk);
      busy_cnt = 0; op_cnt = 0; op_bad = 0; cen_hi_cnt = 0;
      mon_en = 1'b1;
      bist_start = 1'b1;
      @(negedge CLK);
      bist_start = 1'b0;
      cyc = 0;
      while (!bist_done && cyc < 3000) begin
         rand_func();
         bist_start = (cyc == glitch);
         @(negedge CLK);
         cyc++;
      end
      bist_start = 1'b0;
      mon_en = 1'b0;
      chk({nm, "_no_timeout"}, 32'(cyc < 3000), 1);
      chk({nm, "_busy_cycles"}, busy_cnt, 641);
      chk({nm, "_done"}, 32'(bist_done), 1);
      chk({nm, "_busy_low"}, 32'(bist_busy), 0);
      chk({nm, "_op_count"}, op_cnt, NOPS);
      chk({nm, "_op_seq_bad"}, op_bad, 0);
      chk({nm, "_drain_cen_hi"}, cen_hi_cnt, 1);
      chk({nm, "_fail"}, 32'(bist_fail), 32'(ref_err != 0));
      chk({nm, "_err_cnt"}, 32'(bist_err_cnt), ref_err);
      if (ref_err != 0) begin
         chk({nm, "_fail_addr"}, 32'(bist_fail_addr), ref_faddr);
         chk({nm, "_fail_elem"}, 32'(bist_fail_elem), ref_felem);
      end
   endtask

   initial begin
      RESETN = 1'b0;
      bist_start = 1'b0;
      rand_func();
      #1;
      chk_bist_zero("rst");
      chk_passthru("rst_pass");
      repeat (3) @(negedge CLK);
      RESETN = 1'b1;

      run_bist(0, -1, "clean");

      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         rand_func();
         #1;
         chk_passthru("idle_rand");
      end
      @(negedge CLK);
      func_cen = 1'b0; func_gwen = 1'b0; func_wen = '0; func_a = 6'd7; func_d = 32'hDEAD_BEEF;
      #1;
      chk_passthru("idle_wr");
      @(negedge CLK);
      func_gwen = 1'b1; func_wen = '1; func_d = $urandom;
      @(negedge CLK);
      func_cen = 1'b1;
      chk("idle_rd_q", func_q, 32'hDEAD_BEEF);

      run_bist(1, -1, "stuck5");
      chk("stuck5_err_spec", 32'(bist_err_cnt), 3);
      chk("stuck5_addr_spec", 32'(bist_fail_addr), 5);
      chk("stuck5_elem_spec", 32'(bist_fail_elem), 1);

      run_bist(2, -1, "nowr10");
      chk("nowr10_addr_spec", 32'(bist_fail_addr), 10);
      chk("nowr10_elem_ge1", 32'(bist_fail_elem >= 3'd1), 1);
      chk("nowr10_err_nz", 32'(bist_err_cnt != 8'd0), 1);

      run_bist(0, 100, "glitch");

      // Abort mid-run with a fresh start pulse then reset after 300 busy cycles.
      @(negedge CLK);
      bist_start = 1'b1;
      @(negedge CLK);
      bist_start = 1'b0;
      repeat (299) @(negedge CLK);
      chk("midrun_busy", 32'(bist_busy), 1);
      #2;
      RESETN = 1'b0;
      rand_func();
      #1;
      chk_bist_zero("midrun_rst");
      chk_passthru("midrun_pass");
      @(negedge CLK);
      RESETN = 1'b1;
      run_bist(0, -1, "post_rst");

      run_bist(0, 50 + int'($urandom_range(0, 500)), "rand_glitch");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
